// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N_CH programmable divided-clock / tick generator.
// Define CLKDIV_MULTI_IMM_LOAD_EN for loads that restart the channel at once.
module clkdiv_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 28,
    parameter int DEF_DIV  = 100_000_000,
    parameter int DEF_HIGH = DEF_DIV / 2,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0] load_div,
    input  logic [CNT_W-1:0] load_high,
    output logic [N_CH-1:0]  outclk,
    output logic [N_CH-1:0]  tick,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);

    logic ch_ok;
    logic load_ok;

    assign ch_ok   = 32'(load_ch) < 32'(N_CH);
    assign load_ok = load && ch_ok && (load_div >= CNT_W'(2));

    // Flag a rejected load for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CNT_W-1:0] det;
        logic [CNT_W-1:0] div_a;
        logic [CNT_W-1:0] high_a;
        logic             hit;
        logic             wrap;
        logic             restart;
        logic             oc;
        logic             tk;

        assign hit     = load_ok && (load_ch == CH_W'(c));
        assign wrap    = det >= (div_a - CNT_W'(1));
        assign restart = !en[c] || sync;

`ifdef CLKDIV_MULTI_IMM_LOAD_EN
        // Accepted loads take over the channel now and restart its period.
        always_ff @(posedge clk) begin
            if (reset) begin
                det    <= '0;
                div_a  <= DIV_RST;
                high_a <= HIGH_RST;
            end else if (hit) begin
                det    <= '0;
                div_a  <= load_div;
                high_a <= load_high;
            end else if (restart || wrap) begin
                det <= '0;
            end else begin
                det <= det + CNT_W'(1);
            end
        end
`else
        logic [CNT_W-1:0] div_p;
        logic [CNT_W-1:0] high_p;
        logic             pend;
        logic             apply;

        // A period boundary (wrap, sync or idle) is where settings switch.
        assign apply = (restart || wrap) && (hit || pend);

        // Count within the period; swap in pending settings at a boundary.
        always_ff @(posedge clk) begin
            if (reset) begin
                det    <= '0;
                div_a  <= DIV_RST;
                high_a <= HIGH_RST;
                div_p  <= DIV_RST;
                high_p <= HIGH_RST;
                pend   <= 1'b0;
            end else begin
                if (restart || wrap) begin
                    det <= '0;
                end else begin
                    det <= det + CNT_W'(1);
                end
                if (hit) begin
                    div_p  <= load_div;
                    high_p <= load_high;
                end
                if (apply) begin
                    div_a  <= hit ? load_div : div_p;
                    high_a <= hit ? load_high : high_p;
                    pend   <= 1'b0;
                end else if (hit) begin
                    pend <= 1'b1;
                end
            end
        end
`endif

        // Register the channel outputs from the current count.
        always_ff @(posedge clk) begin
            if (reset) begin
                oc <= 1'b0;
                tk <= 1'b0;
            end else begin
                oc <= en[c] && (det < high_a);
                tk <= en[c] && (det == '0);
            end
        end

        assign outclk[c] = oc;
        assign tick[c]   = tk;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed + random stimulus against a timeline model.
// The model tracks the start cycle of each channel's current period.
module tb_clkdiv_multi;

    localparam int NCH   = 2;
    localparam int W     = 8;
    localparam int DDIV  = 10;
    localparam int DHIGH = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           load = 1'b0;
    logic [0:0]     load_ch = '0;
    logic [W-1:0]   load_div = '0;
    logic [W-1:0]   load_high = '0;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] tick;
    logic           load_err;

    clkdiv_multi #(
        .N_CH(NCH), .CNT_W(W), .DEF_DIV(DDIV), .DEF_HIGH(DHIGH)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .load(load), .load_ch(load_ch), .load_div(load_div),
        .load_high(load_high), .outclk(outclk), .tick(tick),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int st[NCH];
    int da[NCH];
    int ha[NCH];
    int dp[NCH];
    int hp[NCH];
    bit pd[NCH];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int phase(int c);
        return cyc - st[c];
    endfunction

    task automatic step();
        logic [NCH-1:0] e_o;
        logic [NCH-1:0] e_t;
        logic e_err;
        bit err;
        bit acc;
        bit hit;
        int ph;
        @(posedge clk);
        err = load && (int'(load_div) < 2 || int'(load_ch) >= NCH);
        acc = load && !err;
        e_err = !reset && err;
        for (int c = 0; c < NCH; c++) begin
            ph = cyc - st[c];
            if (reset) begin
                e_o[c] = 1'b0;
                e_t[c] = 1'b0;
                st[c] = cyc + 1;
                da[c] = DDIV;
                ha[c] = DHIGH;
                dp[c] = DDIV;
                hp[c] = DHIGH;
                pd[c] = 1'b0;
            end else begin
                e_o[c] = en[c] && (ph < ha[c]);
                e_t[c] = en[c] && (ph == 0);
                hit = acc && (int'(load_ch) == c);
`ifdef CLKDIV_MULTI_IMM_LOAD_EN
                if (hit) begin
                    da[c] = int'(load_div);
                    ha[c] = int'(load_high);
                    st[c] = cyc + 1;
                end else if (!en[c] || sync || ph + 1 >= da[c]) begin
                    st[c] = cyc + 1;
                end
`else
                if (hit) begin
                    dp[c] = int'(load_div);
                    hp[c] = int'(load_high);
                    pd[c] = 1'b1;
                end
                if (!en[c] || sync || ph + 1 >= da[c]) begin
                    st[c] = cyc + 1;
                    if (pd[c]) begin
                        da[c] = dp[c];
                        ha[c] = hp[c];
                        pd[c] = 1'b0;
                    end
                end
`endif
            end
        end
        cyc++;
        #1;
        chk("outclk", 32'(outclk), 32'(e_o));
        chk("tick", 32'(tick), 32'(e_t));
        chk("load_err", 32'(load_err), 32'(e_err));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(int ch, int dv, int hi);
        load_ch   = 1'(ch);
        load_div  = W'(dv);
        load_high = W'(hi);
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic wait_ph(int c, int p);
        for (int k = 0; k < 40 && phase(c) != p; k++) step();
        chk("wait_phase", 32'(phase(c)), 32'(p));
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            st[c] = 0;
            da[c] = DDIV;
            ha[c] = DHIGH;
            dp[c] = DDIV;
            hp[c] = DHIGH;
            pd[c] = 1'b0;
        end
        run(3);
        reset = 1'b0;
        run(2);
        en = 2'b11;
        run(25);
        wait_ph(0, 3);
        do_load(0, 4, 1);
        run(24);
        do_load(1, 6, 0);
        run(20);
        do_load(1, 4, 7);
        run(15);
        do_load(0, 1, 2);
        run(6);
        do_load(1, 0, 3);
        run(4);
        do_load(0, 6, 3);
        do_load(1, 9, 4);
        run(13);
        en = 2'b01;
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(8);
        en = 2'b11;
        run(5);
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(12);
        load_ch   = 1'b0;
        load_div  = W'(5);
        load_high = W'(2);
        load      = 1'b1;
        sync      = 1'b1;
        step();
        load = 1'b0;
        sync = 1'b0;
        run(12);
        wait_ph(1, 1);
        do_load(1, 3, 1);
        wait_ph(1, 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(25);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            sync  = ($urandom_range(0, 24) == 0);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
            load      = ($urandom_range(0, 5) == 0);
            load_ch   = 1'($urandom_range(0, 1));
            load_div  = ($urandom_range(0, 9) == 0) ?
                        W'($urandom_range(0, 1)) :
                        W'($urandom_range(2, 12));
            load_high = W'($urandom_range(0, 14));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
